// File: rtl/blob_labeler.sv
// Streaming connected-component counter: union-find labelling, then flatten/accumulate/count.
// Define BLOB_LABELER_8CONN_EN for 8-connectivity; the default build is 4-connected.
module blob_labeler #(
    parameter int IMG_W   = 800,
    parameter int IMG_H   = 600,
    parameter int LABEL_W = 7,
    parameter int CNT_W   = 19,
    parameter int OUT_W   = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [CNT_W-1:0] i_min_size,
    input  logic             i_valid,
    input  logic             i_pix,
    output logic             o_ready,
    output logic             o_busy,
    output logic             o_valid,
    output logic [OUT_W-1:0] o_count,
    output logic             o_overflow,
    input  logic             i_ack
);

    localparam int NL = 2**LABEL_W;
    localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [XW-1:0] XLAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] YLAST = YW'(IMG_H - 1);

    typedef enum logic [2:0] {
        IDLE, CLEAR, STREAM, UNION, FLATTEN, ACCUM, COUNT, DONE
    } state_t;

    state_t state;

    logic [LABEL_W-1:0] parent [NL];
    logic [CNT_W-1:0]   cnt    [NL];
    logic [LABEL_W-1:0] lb     [IMG_W];

    logic [LABEL_W-1:0] idx;
    logic [XW-1:0]      col;
    logic [YW-1:0]      row;
    logic [LABEL_W-1:0] left_q;
    logic [LABEL_W-1:0] nf;
    logic               full_q;
    logic [CNT_W-1:0]   min_q;
    logic [LABEL_W-1:0] ra;
    logic [LABEL_W-1:0] rb;
    logic [LABEL_W-1:0] uc;
    logic               pend;
    logic               u_wr;
    logic               last_q;
    logic [OUT_W-1:0]   blobs;

    logic               acc;
    logic               last_px;
    logic [LABEL_W-1:0] up_n;
    logic [LABEL_W-1:0] lf_n;
    logic [LABEL_W-1:0] c1;
    logic [LABEL_W-1:0] c2;
    logic [LABEL_W-1:0] srt [3];
    logic [LABEL_W-1:0] dl  [3];
    logic [LABEL_W-1:0] prev;
    logic [LABEL_W-1:0] tmp;
    logic [1:0]         nd;
    logic [LABEL_W-1:0] st_lbl;
    logic [LABEL_W-1:0] u_lo;
    logic [LABEL_W-1:0] u_hi;

`ifdef BLOB_LABELER_8CONN_EN
    logic [LABEL_W-1:0] ul_q;
    logic [LABEL_W-1:0] ul_n;
    logic [LABEL_W-1:0] ur_n;
    logic [XW-1:0]      col_r;
`endif

    assign acc     = i_valid && o_ready;
    assign last_px = (col == XLAST) && (row == YLAST);
    assign u_lo    = (ra < rb) ? ra : rb;
    assign u_hi    = (ra < rb) ? rb : ra;

    // Gather neighbour labels, sort ascending, keep distinct nonzero ones.
    always_comb begin
        up_n = (row != '0) ? lb[col] : '0;
        lf_n = (col != '0) ? left_q : '0;
`ifdef BLOB_LABELER_8CONN_EN
        col_r = (col == XLAST) ? col : col + XW'(1);
        ul_n  = (row != '0 && col != '0) ? ul_q : '0;
        ur_n  = (row != '0 && col != XLAST) ? lb[col_r] : '0;
        // up-left and up touch each other, so up already carries up-left's set
        c1 = (up_n != '0) ? up_n : ul_n;
        c2 = ur_n;
`else
        c1 = up_n;
        c2 = '0;
`endif
        srt[0] = lf_n;
        srt[1] = c1;
        srt[2] = c2;
        tmp = srt[0];
        if (srt[0] > srt[1]) begin
            srt[0] = srt[1];
            srt[1] = tmp;
        end
        tmp = srt[1];
        if (srt[1] > srt[2]) begin
            srt[1] = srt[2];
            srt[2] = tmp;
        end
        tmp = srt[0];
        if (srt[0] > srt[1]) begin
            srt[0] = srt[1];
            srt[1] = tmp;
        end
        dl[0] = '0;
        dl[1] = '0;
        dl[2] = '0;
        nd    = 2'd0;
        prev  = '0;
        for (int k = 0; k < 3; k++) begin
            if (srt[k] != '0 && srt[k] != prev) begin
                dl[nd] = srt[k];
                nd     = nd + 2'd1;
            end
            prev = srt[k];
        end
        if (!i_pix)
            st_lbl = '0;
        else if (nd == 2'd0)
            st_lbl = full_q ? '0 : nf;
        else
            st_lbl = dl[0];
    end

    logic               p_we;
    logic [LABEL_W-1:0] p_wa;
    logic [LABEL_W-1:0] p_wd;
    logic               c_we0;
    logic [LABEL_W-1:0] c_wa0;
    logic [CNT_W-1:0]   c_wd0;
    logic               c_we1;
    logic [LABEL_W-1:0] c_wa1;
    logic [CNT_W-1:0]   c_wd1;
    logic [CNT_W-1:0]   c_rd;
    logic [CNT_W:0]     c_sum;
    logic [LABEL_W-1:0] p_idx;

    always_comb begin
        p_we  = 1'b0;
        p_wa  = '0;
        p_wd  = '0;
        c_we0 = 1'b0;
        c_wa0 = '0;
        c_wd0 = '0;
        c_we1 = 1'b0;
        c_wa1 = '0;
        c_wd1 = '0;
        p_idx = parent[idx];
        c_rd  = cnt[dl[0]];
        c_sum = {1'b0, cnt[p_idx]} + {1'b0, cnt[idx]};
        unique case (state)
            CLEAR: begin
                p_we  = 1'b1;
                p_wa  = idx;
                p_wd  = idx;
                c_we0 = 1'b1;
                c_wa0 = idx;
            end
            STREAM: begin
                if (acc && i_pix) begin
                    if (nd == 2'd0) begin
                        c_we0 = !full_q;
                        c_wa0 = nf;
                        c_wd0 = CNT_W'(1);
                    end else begin
                        c_we0 = 1'b1;
                        c_wa0 = dl[0];
                        c_wd0 = (&c_rd) ? c_rd : c_rd + CNT_W'(1);
                    end
                end
            end
            UNION: begin
                p_we = u_wr;
                p_wa = u_hi;
                p_wd = u_lo;
            end
            FLATTEN: begin
                p_we = 1'b1;
                p_wa = idx;
                p_wd = parent[p_idx];
            end
            ACCUM: begin
                if (p_idx != idx) begin
                    c_we0 = 1'b1;
                    c_wa0 = p_idx;
                    c_wd0 = c_sum[CNT_W] ? '1 : c_sum[CNT_W-1:0];
                    c_we1 = 1'b1;
                    c_wa1 = idx;
                end
            end
            default: ;
        endcase
    end

    // Label tables carry no reset: CLEAR rebuilds them at every frame start.
    always_ff @(posedge i_clk) begin
        if (p_we)
            parent[p_wa] <= p_wd;
        if (c_we0)
            cnt[c_wa0] <= c_wd0;
        if (c_we1)
            cnt[c_wa1] <= c_wd1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= IDLE;
            o_ready    <= 1'b0;
            o_busy     <= 1'b0;
            o_valid    <= 1'b0;
            o_count    <= '0;
            o_overflow <= 1'b0;
            idx        <= '0;
            col        <= '0;
            row        <= '0;
            left_q     <= '0;
            nf         <= LABEL_W'(1);
            full_q     <= 1'b0;
            min_q      <= '0;
            ra         <= '0;
            rb         <= '0;
            uc         <= '0;
            pend       <= 1'b0;
            u_wr       <= 1'b0;
            last_q     <= 1'b0;
            blobs      <= '0;
`ifdef BLOB_LABELER_8CONN_EN
            ul_q       <= '0;
`endif
            for (int i = 0; i < IMG_W; i++)
                lb[i] <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (i_start) begin
                        min_q      <= i_min_size;
                        o_overflow <= 1'b0;
                        o_busy     <= 1'b1;
                        idx        <= '0;
                        col        <= '0;
                        row        <= '0;
                        left_q     <= '0;
                        nf         <= LABEL_W'(1);
                        full_q     <= 1'b0;
                        blobs      <= '0;
                        state      <= CLEAR;
                    end
                end
                CLEAR: begin
                    idx <= idx + LABEL_W'(1);
                    if (&idx) begin
                        state   <= STREAM;
                        o_ready <= 1'b1;
                    end
                end
                STREAM: begin
                    if (acc) begin
                        lb[col] <= st_lbl;
                        left_q  <= st_lbl;
`ifdef BLOB_LABELER_8CONN_EN
                        ul_q    <= lb[col];
`endif
                        if (i_pix && nd == 2'd0) begin
                            if (full_q)
                                o_overflow <= 1'b1;
                            else begin
                                nf <= nf + LABEL_W'(1);
                                if (&nf)
                                    full_q <= 1'b1;
                            end
                        end
                        if (col == XLAST) begin
                            col <= '0;
                            row <= (row == YLAST) ? '0 : row + YW'(1);
                        end else begin
                            col <= col + XW'(1);
                        end
                        if (i_pix && nd >= 2'd2) begin
                            state   <= UNION;
                            o_ready <= 1'b0;
                            ra      <= dl[0];
                            rb      <= dl[1];
                            uc      <= dl[2];
                            pend    <= (nd == 2'd3);
                            u_wr    <= 1'b0;
                            last_q  <= last_px;
                        end else if (last_px) begin
                            state   <= FLATTEN;
                            o_ready <= 1'b0;
                            idx     <= '0;
                        end
                    end
                end
                UNION: begin
                    if (!u_wr) begin
                        if (parent[ra] == ra && parent[rb] == rb)
                            u_wr <= 1'b1;
                        else begin
                            ra <= parent[ra];
                            rb <= parent[rb];
                        end
                    end else begin
                        u_wr <= 1'b0;
                        if (pend) begin
                            pend <= 1'b0;
                            ra   <= u_lo;
                            rb   <= uc;
                        end else if (last_q) begin
                            state <= FLATTEN;
                            idx   <= '0;
                        end else begin
                            state   <= STREAM;
                            o_ready <= 1'b1;
                        end
                    end
                end
                FLATTEN: begin
                    idx <= idx + LABEL_W'(1);
                    if (&idx)
                        state <= ACCUM;
                end
                ACCUM: begin
                    idx <= idx + LABEL_W'(1);
                    if (&idx)
                        state <= COUNT;
                end
                COUNT: begin
                    if (idx != '0 && p_idx == idx &&
                        cnt[idx] >= min_q && !(&blobs))
                        blobs <= blobs + OUT_W'(1);
                    idx <= idx + LABEL_W'(1);
                    if (&idx) begin
                        state  <= DONE;
                        o_busy <= 1'b0;
                    end
                end
                DONE: begin
                    if (!o_valid) begin
                        o_valid <= 1'b1;
                        o_count <= blobs;
                    end else if (i_ack) begin
                        o_valid <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_blob_labeler.sv
// Directed-vector bench for blob_labeler on an 8x6 image with 16 labels.
module tb_blob_labeler;

    localparam int W  = 8;
    localparam int H  = 6;
    localparam int LW = 4;
    localparam int CW = 19;
    localparam int OW = 8;
    localparam int NP = W * H;
    localparam int LAT = 3 * (2**LW) + 1;

`ifdef BLOB_LABELER_8CONN_EN
    localparam int DIAG_CNT = 1;
    localparam int CHK_CNT  = 1;
    localparam int CHK_OVF  = 0;
`else
    localparam int DIAG_CNT = 2;
    localparam int CHK_CNT  = 15;
    localparam int CHK_OVF  = 1;
`endif

    logic          clk = 1'b0;
    logic          i_rst_n;
    logic          i_start;
    logic [CW-1:0] i_min_size;
    logic          i_valid;
    logic          i_pix;
    logic          o_ready;
    logic          o_busy;
    logic          o_valid;
    logic [OW-1:0] o_count;
    logic          o_overflow;
    logic          i_ack;

    always #5 clk = ~clk;

    blob_labeler #(
        .IMG_W(W), .IMG_H(H), .LABEL_W(LW),
        .CNT_W(CW), .OUT_W(OW)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (i_rst_n),
        .i_start   (i_start),
        .i_min_size(i_min_size),
        .i_valid   (i_valid),
        .i_pix     (i_pix),
        .o_ready   (o_ready),
        .o_busy    (o_busy),
        .o_valid   (o_valid),
        .o_count   (o_count),
        .o_overflow(o_overflow),
        .i_ack     (i_ack)
    );

    typedef struct {
        string       name;
        logic [47:0] img;
        int          min_sz;
        int          exp_cnt;
        int          exp_ovf;
    } vec_t;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Image bit r*W+c is pixel (row r, col c); rows listed 5..0.
    function automatic logic [47:0] mk(input logic [7:0] r5, r4, r3,
                                       input logic [7:0] r2, r1, r0);
        return {r5, r4, r3, r2, r1, r0};
    endfunction

    task automatic run_frame(input string nm, input logic [47:0] img,
                             input int min_sz, input int hold,
                             output int cnt, output int ovf,
                             output int lat, output int maxlow,
                             output int held, output int ackv);
        int k;
        int guard;
        int low;
        bit gap;
        k = 0; guard = 0; low = 0; gap = 0;
        maxlow = 0; lat = 0; held = 0;
        @(negedge clk);
        i_min_size = CW'(min_sz);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        while (!o_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check({nm, "_ready_rise"}, int'(o_ready), 1);
        while (k < NP && guard < 2000) begin
            if (k == 10 && !gap) begin
                i_valid = 1'b0;
                gap = 1;
            end else begin
                i_valid = 1'b1;
                i_pix = img[k];
                if (o_ready) begin
                    k++;
                    low = 0;
                end else begin
                    low++;
                    if (low > maxlow) maxlow = low;
                end
            end
            @(negedge clk);
            guard++;
        end
        i_valid = 1'b0;
        i_pix = 1'b0;
        check({nm, "_all_pixels"}, k, NP);
        while (!o_valid && lat < 300) begin
            @(negedge clk);
            lat++;
        end
        cnt = int'(o_count);
        ovf = int'(o_overflow);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (o_valid && int'(o_count) == cnt) held++;
        end
        i_ack = 1'b1;
        @(negedge clk);
        i_ack = 1'b0;
        ackv = int'(o_valid);
    endtask

    vec_t vt [10];

    initial begin
        int cnt, ovf, lat, ml, held, ackv;
        logic [47:0] sq, uu, dg, cb, full, plus;

        sq   = mk(8'h00, 8'h60, 8'h60, 8'h06, 8'h06, 8'h00);
        uu   = mk(8'h00, 8'h1E, 8'h12, 8'h12, 8'h12, 8'h12);
        dg   = mk(8'h00, 8'h00, 8'h00, 8'h04, 8'h02, 8'h00);
        cb   = mk(8'hAA, 8'h55, 8'hAA, 8'h55, 8'hAA, 8'h55);
        full = {48{1'b1}};
        plus = mk(8'h00, 8'h10, 8'h38, 8'h10, 8'h00, 8'h01);

        vt[0] = '{"zero",     48'h0, 1,  0,        0};
        vt[1] = '{"squares",  sq,    1,  2,        0};
        vt[2] = '{"sq_min4",  sq,    4,  2,        0};
        vt[3] = '{"sq_min5",  sq,    5,  0,        0};
        vt[4] = '{"u_shape",  uu,    1,  1,        0};
        vt[5] = '{"diagonal", dg,    1,  DIAG_CNT, 0};
        vt[6] = '{"checker",  cb,    1,  CHK_CNT,  CHK_OVF};
        vt[7] = '{"full_48",  full,  48, 1,        0};
        vt[8] = '{"full_49",  full,  49, 0,        0};
        vt[9] = '{"plus_1_5", plus,  3,  1,        0};

        i_rst_n = 1'b0;
        i_start = 1'b0;
        i_min_size = '0;
        i_valid = 1'b0;
        i_pix = 1'b0;
        i_ack = 1'b0;
        repeat (3) @(negedge clk);
        i_rst_n = 1'b1;
        @(negedge clk);

        check("rst_ready", int'(o_ready), 0);
        check("rst_busy", int'(o_busy), 0);
        check("rst_valid", int'(o_valid), 0);
        check("rst_count", int'(o_count), 0);
        check("rst_overflow", int'(o_overflow), 0);

        for (int v = 0; v < 10; v++) begin
            run_frame(vt[v].name, vt[v].img, vt[v].min_sz, 0,
                      cnt, ovf, lat, ml, held, ackv);
            check({vt[v].name, "_count"}, cnt, vt[v].exp_cnt);
            check({vt[v].name, "_overflow"}, ovf, vt[v].exp_ovf);
            check({vt[v].name, "_latency"}, lat, LAT);
            check({vt[v].name, "_ack_clears"}, ackv, 0);
            if (v == 4)
                check("u_join_ready_low", int'(ml >= 2), 1);
        end

        // Abort a frame with an asynchronous reset, then run it again.
        @(negedge clk);
        i_min_size = CW'(3);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        repeat (20) @(negedge clk);
        check("mid_busy", int'(o_busy), 1);
        for (int k = 0; k < 20; k++) begin
            i_valid = 1'b1;
            i_pix = plus[k];
            @(negedge clk);
        end
        #2;
        i_rst_n = 1'b0;
        #1;
        check("mid_rst_busy", int'(o_busy), 0);
        check("mid_rst_ready", int'(o_ready), 0);
        i_valid = 1'b0;
        i_pix = 1'b0;
        @(negedge clk);
        i_rst_n = 1'b1;
        @(negedge clk);
        check("mid_rst_valid", int'(o_valid), 0);

        run_frame("restart", plus, 3, 6, cnt, ovf, lat, ml, held, ackv);
        check("restart_count", cnt, 1);
        check("restart_overflow", ovf, 0);
        check("restart_latency", lat, LAT);
        check("restart_hold", held, 6);
        check("restart_ack_clears", ackv, 0);
        @(negedge clk);
        check("restart_idle_busy", int'(o_busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
